ysyx_23060077_axi_arbiter: RTL and testbench
============================================

Name: ysyx_23060077_axi_arbiter

Overview:
- Shares the single CPU-side port of the AXI master bridge between two requesters.
- IFU issues instruction fetches, read only. LSU issues loads and stores, read and write.
- Read requests are arbitrated and the grant is held until the burst's last beat. Request fields are latched at grant so the bridge sees stable values. Responses are routed back to the grant owner.
- LSU writes are sequenced through a separate write FSM. A pending LSU write blocks LSU reads for memory ordering.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 64, data width
- SIZE_W, 3, AXI size field width
- LEN_W, 8, AXI len field width

Ports:
- aclk  in  1  clock
- areset_n  in  1  reset: areset_n, synchronous, active-low; clock aclk
- ifu_r_valid_i  in  1  IFU read request (level, held until last beat)
- ifu_r_addr_i  in  ADDR_W  IFU read address
- ifu_r_size_i  in  SIZE_W  IFU read size
- ifu_r_len_i  in  LEN_W  IFU burst length-1
- ifu_r_ready_o  out  1  IFU beat valid
- ifu_r_data_o  out  DATA_W  IFU beat data
- ifu_r_last_o  out  1  IFU last beat
- lsu_r_valid_i  in  1  LSU read request; lsu_r_addr_i/size_i/len_i as IFU
- lsu_r_ready_o  out  1  LSU beat valid; lsu_r_data_o/lsu_r_last_o as IFU
- lsu_w_valid_i  in  1  LSU write request (level)
- lsu_w_addr_i  in  ADDR_W  write address
- lsu_w_data_i  in  DATA_W  write data
- lsu_w_size_i  in  SIZE_W  write size
- lsu_w_len_i  in  LEN_W  write length-1
- lsu_w_ready_o  out  1  write beat accepted
- lsu_w_last_o  out  1  write response received
- bus_r_valid_o  out  1  to bridge cpu_r_valid
- bus_r_addr_o  out  ADDR_W  latched read address
- bus_r_size_o  out  SIZE_W  latched read size
- bus_r_len_o  out  LEN_W  latched read length
- bus_r_ready_i  in  1  bridge beat valid
- bus_r_data_i  in  DATA_W  bridge beat data
- bus_r_last_i  in  1  bridge last beat
- bus_w_valid_o  out  1  to bridge cpu_w_valid; bus_w_addr_o/data_o/size_o/len_o latched/forwarded
- bus_w_ready_i  in  1  bridge write beat accepted
- bus_w_last_i  in  1  bridge write response

Behaviour:
- Reset (areset_n=0 at posedge):
  - Read FSM goes to R_IDLE. Write FSM goes to W_IDLE.
  - bus_r_valid_o=0, bus_w_valid_o=0. Latched fields go to 0.
  - Round-robin pointer goes to IFU.
  - All requester outputs are 0.
  - Reset mid-burst abandons the transaction; no beat is routed after reset.
- Read FSM:
  - R_IDLE → R_IFU or R_LSU when a request is eligible.
  - LSU read is eligible only if the write FSM is in W_IDLE and lsu_w_valid_i=0. Writes go first.
  - When both are eligible, fixed priority applies: LSU wins (see optional feature).
  - On grant, addr/size/len are latched into bus_r_*_o and bus_r_valid_o is set to 1, one cycle after the request.
  - R_IFU/R_LSU: bus_r_valid_o stays 1. The owner's ready/data/last equal bus_r_ready_i/bus_r_data_i/bus_r_last_i, combinational. The non-owner sees ready=0, last=0, data=0.
  - When bus_r_ready_i & bus_r_last_i: bus_r_valid_o is cleared at that edge and the FSM goes to R_IDLE.
  - A requester must drop valid the cycle after its last beat. A valid still high in R_IDLE is a new request.
  - Minimum gap between consecutive grants is 1 idle cycle.
- Write FSM:
  - W_IDLE → W_BUSY when lsu_w_valid_i=1 and the read FSM is not in R_LSU. An IFU read in flight does not block.
  - On entry, addr/size/len are latched and bus_w_valid_o is set to 1.
  - Data is forwarded combinationally.
  - lsu_w_ready_o=bus_w_ready_i in W_BUSY, else 0.
  - W_BUSY: on bus_w_last_i, lsu_w_last_o=1 for that cycle, bus_w_valid_o is cleared, and the FSM returns to W_IDLE.
- Simultaneous events:
  - LSU read and LSU write both valid → write taken first.
  - IFU read can start in the same cycle a write starts.
- Burst length: len field passed unmodified. Beat counting is done by the bridge; the arbiter relies only on last.

Optional Feature:
- AXI_ARB_RR_EN defined: round-robin read arbitration.
  - A 1-bit pointer records the last owner.
  - On a tie, the non-last owner wins.
  - The pointer updates at each grant.
- Undefined: fixed priority, LSU over IFU. The pointer logic is absent.

Test Plan:
- IFU only, addr 0x8000_0000, len 0: bus_r_valid_o high 1 cycle later with addr latched. Bridge returns data 0x1234 with last → ifu_r_ready_o=1, ifu_r_data_o=0x1234, ifu_r_last_o=1. Next cycle bus_r_valid_o=0.
- IFU and LSU reads in the same cycle, no macro → LSU granted first. IFU granted after LSU last plus 1 idle cycle. With AXI_ARB_RR_EN and last owner LSU → IFU first.
- LSU write 0x8000_0100 data 0xDEAD_BEEF plus LSU read pending → write completes (lsu_w_last_o pulse), then LSU read granted. bus_r_valid_o is never high for LSU during W_BUSY.
- IFU burst len 3 (4 beats) → exactly 4 ifu_r_ready_o pulses, last only on the 4th. lsu_r_ready_o stays 0 throughout.
- areset_n low during the 2nd beat of an IFU burst → next cycle both FSMs idle, all valids 0, no further ifu_r_ready_o.
- IFU read in flight, LSU write arrives → write starts in parallel. Both complete; lsu_w_last_o and ifu_r_last_o each pulse once.

Source files
------------

// File: rtl/ysyx_23060077_axi_arbiter.sv
// Shares the CPU-side AXI bridge port between IFU (read) and LSU (read/write).
// Define AXI_ARB_RR_EN for round-robin read arbitration; default is fixed LSU-over-IFU priority.
module ysyx_23060077_axi_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int SIZE_W = 3,
   parameter int LEN_W  = 8
) (
   input  logic              aclk,
   input  logic              areset_n,

   input  logic              ifu_r_valid_i,
   input  logic [ADDR_W-1:0] ifu_r_addr_i,
   input  logic [SIZE_W-1:0] ifu_r_size_i,
   input  logic [LEN_W-1:0]  ifu_r_len_i,
   output logic              ifu_r_ready_o,
   output logic [DATA_W-1:0] ifu_r_data_o,
   output logic              ifu_r_last_o,

   input  logic              lsu_r_valid_i,
   input  logic [ADDR_W-1:0] lsu_r_addr_i,
   input  logic [SIZE_W-1:0] lsu_r_size_i,
   input  logic [LEN_W-1:0]  lsu_r_len_i,
   output logic              lsu_r_ready_o,
   output logic [DATA_W-1:0] lsu_r_data_o,
   output logic              lsu_r_last_o,

   input  logic              lsu_w_valid_i,
   input  logic [ADDR_W-1:0] lsu_w_addr_i,
   input  logic [DATA_W-1:0] lsu_w_data_i,
   input  logic [SIZE_W-1:0] lsu_w_size_i,
   input  logic [LEN_W-1:0]  lsu_w_len_i,
   output logic              lsu_w_ready_o,
   output logic              lsu_w_last_o,

   output logic              bus_r_valid_o,
   output logic [ADDR_W-1:0] bus_r_addr_o,
   output logic [SIZE_W-1:0] bus_r_size_o,
   output logic [LEN_W-1:0]  bus_r_len_o,
   input  logic              bus_r_ready_i,
   input  logic [DATA_W-1:0] bus_r_data_i,
   input  logic              bus_r_last_i,

   output logic              bus_w_valid_o,
   output logic [ADDR_W-1:0] bus_w_addr_o,
   output logic [DATA_W-1:0] bus_w_data_o,
   output logic [SIZE_W-1:0] bus_w_size_o,
   output logic [LEN_W-1:0]  bus_w_len_o,
   input  logic              bus_w_ready_i,
   input  logic              bus_w_last_i
);

   typedef enum logic [1:0] {R_IDLE, R_IFU, R_LSU} rstate_e;
   typedef enum logic       {W_IDLE, W_BUSY}       wstate_e;

   rstate_e           r_state_q, r_state_d;
   wstate_e           w_state_q, w_state_d;

   logic [ADDR_W-1:0] r_addr_q, r_addr_d;
   logic [SIZE_W-1:0] r_size_q, r_size_d;
   logic [LEN_W-1:0]  r_len_q,  r_len_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic [SIZE_W-1:0] w_size_q, w_size_d;
   logic [LEN_W-1:0]  w_len_q,  w_len_d;

   logic ifu_req;
   logic lsu_req;
   logic pick_lsu;
   logic r_own_ifu;
   logic r_own_lsu;
   logic w_busy;

   // LSU reads wait for any pending or in-progress write to keep memory order
   assign ifu_req = ifu_r_valid_i;
   assign lsu_req = lsu_r_valid_i && (w_state_q == W_IDLE) && !lsu_w_valid_i;

`ifdef AXI_ARB_RR_EN
   logic last_lsu_q, last_lsu_d;

   // On a tie the requester that did not own the bus last time wins
   assign pick_lsu = lsu_req && (!ifu_req || !last_lsu_q);

   always_comb begin
      last_lsu_d = last_lsu_q;
      if (r_state_q == R_IDLE) begin
         if (pick_lsu)     last_lsu_d = 1'b1;
         else if (ifu_req) last_lsu_d = 1'b0;
      end
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) last_lsu_q <= 1'b0;
      else           last_lsu_q <= last_lsu_d;
   end
`else
   assign pick_lsu = lsu_req;
`endif

   always_comb begin
      r_state_d = r_state_q;
      r_addr_d  = r_addr_q;
      r_size_d  = r_size_q;
      r_len_d   = r_len_q;
      case (r_state_q)
         R_IDLE: begin
            if (pick_lsu) begin
               r_state_d = R_LSU;
               r_addr_d  = lsu_r_addr_i;
               r_size_d  = lsu_r_size_i;
               r_len_d   = lsu_r_len_i;
            end else if (ifu_req) begin
               r_state_d = R_IFU;
               r_addr_d  = ifu_r_addr_i;
               r_size_d  = ifu_r_size_i;
               r_len_d   = ifu_r_len_i;
            end
         end
         R_IFU, R_LSU: begin
            if (bus_r_ready_i && bus_r_last_i) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      w_state_d = w_state_q;
      w_addr_d  = w_addr_q;
      w_size_d  = w_size_q;
      w_len_d   = w_len_q;
      case (w_state_q)
         W_IDLE: begin
            if (lsu_w_valid_i && (r_state_q != R_LSU)) begin
               w_state_d = W_BUSY;
               w_addr_d  = lsu_w_addr_i;
               w_size_d  = lsu_w_size_i;
               w_len_d   = lsu_w_len_i;
            end
         end
         W_BUSY: begin
            if (bus_w_last_i) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         r_state_q <= R_IDLE;
         r_addr_q  <= '0;
         r_size_q  <= '0;
         r_len_q   <= '0;
         w_state_q <= W_IDLE;
         w_addr_q  <= '0;
         w_size_q  <= '0;
         w_len_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_addr_q  <= r_addr_d;
         r_size_q  <= r_size_d;
         r_len_q   <= r_len_d;
         w_state_q <= w_state_d;
         w_addr_q  <= w_addr_d;
         w_size_q  <= w_size_d;
         w_len_q   <= w_len_d;
      end
   end

   // Valids are high exactly while the corresponding FSM holds a transaction
   assign r_own_ifu = (r_state_q == R_IFU);
   assign r_own_lsu = (r_state_q == R_LSU);
   assign w_busy    = (w_state_q == W_BUSY);

   assign bus_r_valid_o = r_own_ifu || r_own_lsu;
   assign bus_r_addr_o  = r_addr_q;
   assign bus_r_size_o  = r_size_q;
   assign bus_r_len_o   = r_len_q;

   assign ifu_r_ready_o = r_own_ifu && bus_r_ready_i;
   assign ifu_r_last_o  = r_own_ifu && bus_r_last_i;
   assign ifu_r_data_o  = r_own_ifu ? bus_r_data_i : '0;
   assign lsu_r_ready_o = r_own_lsu && bus_r_ready_i;
   assign lsu_r_last_o  = r_own_lsu && bus_r_last_i;
   assign lsu_r_data_o  = r_own_lsu ? bus_r_data_i : '0;

   assign bus_w_valid_o = w_busy;
   assign bus_w_addr_o  = w_addr_q;
   assign bus_w_data_o  = lsu_w_data_i;
   assign bus_w_size_o  = w_size_q;
   assign bus_w_len_o   = w_len_q;
   assign lsu_w_ready_o = w_busy && bus_w_ready_i;
   assign lsu_w_last_o  = w_busy && bus_w_last_i;

endmodule

// File: tb/tb_ysyx_23060077_axi_arbiter.sv
// Scoreboard bench for ysyx_23060077_axi_arbiter: stimulus pushes expected grants/beats,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_ysyx_23060077_axi_arbiter;

   localparam int K_GRANT = 0;
   localparam int K_WDONE = 1;
   localparam int K_IFU   = 2;
   localparam int K_LSU   = 3;

   typedef struct {
      int          k;
      logic [63:0] a;
      logic [63:0] b;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   logic rv_prev = 1'b0;

   logic        aclk = 1'b0;
   logic        areset_n;
   logic        ifu_r_valid_i;
   logic [31:0] ifu_r_addr_i;
   logic [2:0]  ifu_r_size_i;
   logic [7:0]  ifu_r_len_i;
   logic        ifu_r_ready_o;
   logic [63:0] ifu_r_data_o;
   logic        ifu_r_last_o;
   logic        lsu_r_valid_i;
   logic [31:0] lsu_r_addr_i;
   logic [2:0]  lsu_r_size_i;
   logic [7:0]  lsu_r_len_i;
   logic        lsu_r_ready_o;
   logic [63:0] lsu_r_data_o;
   logic        lsu_r_last_o;
   logic        lsu_w_valid_i;
   logic [31:0] lsu_w_addr_i;
   logic [63:0] lsu_w_data_i;
   logic [2:0]  lsu_w_size_i;
   logic [7:0]  lsu_w_len_i;
   logic        lsu_w_ready_o;
   logic        lsu_w_last_o;
   logic        bus_r_valid_o;
   logic [31:0] bus_r_addr_o;
   logic [2:0]  bus_r_size_o;
   logic [7:0]  bus_r_len_o;
   logic        bus_r_ready_i;
   logic [63:0] bus_r_data_i;
   logic        bus_r_last_i;
   logic        bus_w_valid_o;
   logic [31:0] bus_w_addr_o;
   logic [63:0] bus_w_data_o;
   logic [2:0]  bus_w_size_o;
   logic [7:0]  bus_w_len_o;
   logic        bus_w_ready_i;
   logic        bus_w_last_i;

   ysyx_23060077_axi_arbiter #(
      .ADDR_W(32), .DATA_W(64), .SIZE_W(3), .LEN_W(8)
   ) dut (
      .aclk(aclk), .areset_n(areset_n),
      .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_addr_i(ifu_r_addr_i),
      .ifu_r_size_i(ifu_r_size_i), .ifu_r_len_i(ifu_r_len_i),
      .ifu_r_ready_o(ifu_r_ready_o), .ifu_r_data_o(ifu_r_data_o), .ifu_r_last_o(ifu_r_last_o),
      .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i),
      .lsu_r_size_i(lsu_r_size_i), .lsu_r_len_i(lsu_r_len_i),
      .lsu_r_ready_o(lsu_r_ready_o), .lsu_r_data_o(lsu_r_data_o), .lsu_r_last_o(lsu_r_last_o),
      .lsu_w_valid_i(lsu_w_valid_i), .lsu_w_addr_i(lsu_w_addr_i), .lsu_w_data_i(lsu_w_data_i),
      .lsu_w_size_i(lsu_w_size_i), .lsu_w_len_i(lsu_w_len_i),
      .lsu_w_ready_o(lsu_w_ready_o), .lsu_w_last_o(lsu_w_last_o),
      .bus_r_valid_o(bus_r_valid_o), .bus_r_addr_o(bus_r_addr_o),
      .bus_r_size_o(bus_r_size_o), .bus_r_len_o(bus_r_len_o),
      .bus_r_ready_i(bus_r_ready_i), .bus_r_data_i(bus_r_data_i), .bus_r_last_i(bus_r_last_i),
      .bus_w_valid_o(bus_w_valid_o), .bus_w_addr_o(bus_w_addr_o), .bus_w_data_o(bus_w_data_o),
      .bus_w_size_o(bus_w_size_o), .bus_w_len_o(bus_w_len_o),
      .bus_w_ready_i(bus_w_ready_i), .bus_w_last_i(bus_w_last_i)
   );

   always #5 aclk = ~aclk;

   function automatic string kname(input int k);
      case (k)
         K_GRANT: return "grant";
         K_WDONE: return "wdone";
         K_IFU:   return "ifu_beat";
         default: return "lsu_beat";
      endcase
   endfunction

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endfunction

   function automatic void push(input int k, input logic [63:0] a, input logic [63:0] b);
      ev_t e;
      e.k = k; e.a = a; e.b = b;
      exp_q.push_back(e);
   endfunction

   function automatic void observe(input int k, input logic [63:0] a, input logic [63:0] b);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got a=%h b=%h, required no event", kname(k), a, b);
      end else begin
         e = exp_q.pop_front();
         if (e.k != k || e.a !== a || e.b !== b) begin
            errors++;
            $display("FAIL ev_%s: got %s a=%h b=%h, required %s a=%h b=%h",
                     kname(e.k), kname(k), a, b, kname(e.k), e.a, e.b);
         end
      end
   endfunction

   // Fixed per-cycle order: grant, write completion, IFU beat, LSU beat
   always @(negedge aclk) begin
      if (bus_r_valid_o === 1'b1 && rv_prev !== 1'b1)
         observe(K_GRANT, {32'b0, bus_r_addr_o}, {56'b0, bus_r_len_o});
      if (lsu_w_last_o === 1'b1) observe(K_WDONE, {32'b0, bus_w_addr_o}, bus_w_data_o);
      if (ifu_r_ready_o === 1'b1) observe(K_IFU, ifu_r_data_o, {63'b0, ifu_r_last_o});
      if (lsu_r_ready_o === 1'b1) observe(K_LSU, lsu_r_data_o, {63'b0, lsu_r_last_o});
      rv_prev = bus_r_valid_o;
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic rbeat(input bit to_ifu, input logic [63:0] d, input logic last);
      push(to_ifu ? K_IFU : K_LSU, d, {63'b0, last});
      bus_r_ready_i = 1'b1; bus_r_data_i = d; bus_r_last_i = last;
      tick();
      bus_r_ready_i = 1'b0; bus_r_data_i = '0; bus_r_last_i = 1'b0;
   endtask

   // Single-beat read for a requester whose valid/addr are already driven
   task automatic serve_read(input bit to_ifu, input logic [31:0] addr, input logic [63:0] d);
      chk("idle_before_grant", bus_r_valid_o, 1'b0);
      push(K_GRANT, {32'b0, addr}, 64'd0);
      tick();
      chk("grant_valid", bus_r_valid_o, 1'b1);
      rbeat(to_ifu, d, 1'b1);
      if (to_ifu) ifu_r_valid_i = 1'b0;
      else        lsu_r_valid_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit rr;
`ifdef AXI_ARB_RR_EN
      rr = 1'b1;
`else
      rr = 1'b0;
`endif
      areset_n = 1'b0;
      ifu_r_valid_i = 0; ifu_r_addr_i = '0; ifu_r_size_i = 3'd3; ifu_r_len_i = '0;
      lsu_r_valid_i = 0; lsu_r_addr_i = '0; lsu_r_size_i = 3'd3; lsu_r_len_i = '0;
      lsu_w_valid_i = 0; lsu_w_addr_i = '0; lsu_w_data_i = '0; lsu_w_size_i = 3'd3; lsu_w_len_i = '0;
      bus_r_ready_i = 0; bus_r_data_i = '0; bus_r_last_i = 0;
      bus_w_ready_i = 0; bus_w_last_i = 0;
      repeat (2) tick();

      chk("rst_bus_r_valid", bus_r_valid_o, 1'b0);
      chk("rst_bus_w_valid", bus_w_valid_o, 1'b0);
      chk("rst_bus_r_addr", bus_r_addr_o, 32'h0);
      chk("rst_bus_w_addr", bus_w_addr_o, 32'h0);
      chk("rst_ifu_ready", ifu_r_ready_o, 1'b0);
      chk("rst_lsu_w_ready", lsu_w_ready_o, 1'b0);
      areset_n = 1'b1;
      tick();

      // IFU only, single beat
      ifu_r_valid_i = 1; ifu_r_addr_i = 32'h8000_0000; ifu_r_len_i = 8'd0;
      serve_read(1'b1, 32'h8000_0000, 64'h1234);
      chk("t1_valid_cleared", bus_r_valid_o, 1'b0);
      chk("t1_size_latched", bus_r_size_o, 3'd3);

      // Simultaneous reads, pointer at IFU: LSU first in both modes
      ifu_r_valid_i = 1; ifu_r_addr_i = 32'h8000_1000;
      lsu_r_valid_i = 1; lsu_r_addr_i = 32'h8000_2000; lsu_r_len_i = 8'd0;
      serve_read(1'b0, 32'h8000_2000, 64'hA5A5);
      serve_read(1'b1, 32'h8000_1000, 64'h5A5A);

      // LSU alone, then a tie with LSU as last owner
      lsu_r_valid_i = 1; lsu_r_addr_i = 32'h8000_2100;
      serve_read(1'b0, 32'h8000_2100, 64'h11);
      ifu_r_valid_i = 1; ifu_r_addr_i = 32'h8000_1100;
      lsu_r_valid_i = 1; lsu_r_addr_i = 32'h8000_2200;
      if (rr) begin
         serve_read(1'b1, 32'h8000_1100, 64'h21);
         serve_read(1'b0, 32'h8000_2200, 64'h22);
      end else begin
         serve_read(1'b0, 32'h8000_2200, 64'h22);
         serve_read(1'b1, 32'h8000_1100, 64'h21);
      end

      // LSU write with LSU read pending: write first
      lsu_w_valid_i = 1; lsu_w_addr_i = 32'h8000_0100; lsu_w_data_i = 64'hDEAD_BEEF; lsu_w_len_i = 8'd0;
      lsu_r_valid_i = 1; lsu_r_addr_i = 32'h8000_3000;
      tick();
      chk("t3_w_valid", bus_w_valid_o, 1'b1);
      chk("t3_w_addr", bus_w_addr_o, 32'h8000_0100);
      chk("t3_w_data", bus_w_data_o, 64'hDEAD_BEEF);
      chk("t3_r_blocked0", bus_r_valid_o, 1'b0);
      bus_w_ready_i = 1;
      #1;
      chk("t3_w_ready", lsu_w_ready_o, 1'b1);
      tick();
      bus_w_ready_i = 0;
      chk("t3_r_blocked1", bus_r_valid_o, 1'b0);
      tick();
      chk("t3_r_blocked2", bus_r_valid_o, 1'b0);
      bus_w_last_i = 1;
      push(K_WDONE, 64'h8000_0100, 64'hDEAD_BEEF);
      tick();
      bus_w_last_i = 0; lsu_w_valid_i = 0;
      chk("t3_w_cleared", bus_w_valid_o, 1'b0);
      serve_read(1'b0, 32'h8000_3000, 64'hCAFE);

      // IFU burst of 4 beats with a stall between beats 2 and 3
      ifu_r_valid_i = 1; ifu_r_addr_i = 32'h8000_4000; ifu_r_len_i = 8'd3;
      push(K_GRANT, 64'h8000_4000, 64'd3);
      tick();
      rbeat(1'b1, 64'h4001, 1'b0);
      rbeat(1'b1, 64'h4002, 1'b0);
      bus_r_data_i = 64'h77;
      #1;
      chk("t4_stall_ready", ifu_r_ready_o, 1'b0);
      chk("t4_nonowner_data", lsu_r_data_o, 64'h0);
      chk("t4_owner_data", ifu_r_data_o, 64'h77);
      tick();
      rbeat(1'b1, 64'h4003, 1'b0);
      rbeat(1'b1, 64'h4004, 1'b1);
      ifu_r_valid_i = 0;
      chk("t4_valid_cleared", bus_r_valid_o, 1'b0);
      tick();

      // Reset during the second beat of an IFU burst
      ifu_r_valid_i = 1; ifu_r_addr_i = 32'h8000_5000; ifu_r_len_i = 8'd3;
      push(K_GRANT, 64'h8000_5000, 64'd3);
      tick();
      rbeat(1'b1, 64'h5001, 1'b0);
      push(K_IFU, 64'h5002, 64'd0);
      bus_r_ready_i = 1; bus_r_data_i = 64'h5002; bus_r_last_i = 0;
      areset_n = 0;
      tick();
      areset_n = 1; ifu_r_valid_i = 0; bus_r_data_i = 64'h5003;
      chk("t5_r_valid", bus_r_valid_o, 1'b0);
      chk("t5_w_valid", bus_w_valid_o, 1'b0);
      chk("t5_ifu_ready", ifu_r_ready_o, 1'b0);
      chk("t5_addr_cleared", bus_r_addr_o, 32'h0);
      chk("t5_len_cleared", bus_r_len_o, 8'd0);
      tick();
      bus_r_ready_i = 0; bus_r_data_i = '0;
      tick();

      // IFU read in flight, LSU write starts alongside
      ifu_r_valid_i = 1; ifu_r_addr_i = 32'h8000_6000; ifu_r_len_i = 8'd1;
      push(K_GRANT, 64'h8000_6000, 64'd1);
      tick();
      lsu_w_valid_i = 1; lsu_w_addr_i = 32'h8000_0200; lsu_w_data_i = 64'h55AA;
      tick();
      chk("t6_w_valid", bus_w_valid_o, 1'b1);
      chk("t6_r_valid", bus_r_valid_o, 1'b1);
      rbeat(1'b1, 64'h6001, 1'b0);
      bus_w_last_i = 1;
      push(K_WDONE, 64'h8000_0200, 64'h55AA);
      tick();
      bus_w_last_i = 0; lsu_w_valid_i = 0;
      rbeat(1'b1, 64'h6002, 1'b1);
      ifu_r_valid_i = 0;
      tick();

      // IFU read and LSU write start together and finish together
      ifu_r_valid_i = 1; ifu_r_addr_i = 32'h8000_7000; ifu_r_len_i = 8'd0;
      lsu_w_valid_i = 1; lsu_w_addr_i = 32'h8000_0300; lsu_w_data_i = 64'h7777;
      push(K_GRANT, 64'h8000_7000, 64'd0);
      tick();
      chk("t7_w_valid", bus_w_valid_o, 1'b1);
      chk("t7_r_valid", bus_r_valid_o, 1'b1);
      bus_w_last_i = 1;
      push(K_WDONE, 64'h8000_0300, 64'h7777);
      rbeat(1'b1, 64'h7000, 1'b1);
      bus_w_last_i = 0; lsu_w_valid_i = 0; ifu_r_valid_i = 0;
      chk("t7_w_cleared", bus_w_valid_o, 1'b0);
      chk("t7_r_cleared", bus_r_valid_o, 1'b0);

      repeat (3) tick();
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
